pic_priority_isr: RTL and testbench
===================================

# pic_priority_isr

Priority resolver and in-service register (ISR) stage of the 8259-style PIC. It sits directly downstream of the interrupt request register and consumes its masked 8-bit request vector. It arbitrates among requests under fully-nested or automatic-rotation priority and raises `int_out` to the CPU. It runs the two-pulse INTA acknowledge sequence, drives the interrupt vector, and retires in-service levels on EOI or automatic EOI.

## Interface
- `NUM_IRQ`, default 8: number of request levels; fixed at 8 for this design.
- `clk` in 1: single system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `irr` in 8: pending requests from the IRR, already masked; bit n is level n.
- `automatic_rotate` in 1: 1 = after a level is retired, it becomes lowest priority.
- `auto_eoi` in 1: 1 = the ISR bit is cleared at the second INTA.
- `vector_base` in 5: vector bits [7:3] from ICW2.
- `inta` in 1: one-cycle pulse per CPU INTA strobe, already synchronised by control logic.
- `eoi` in 1: one-cycle non-specific EOI command.
- `specific_eoi` in 1: one-cycle specific EOI command.
- `eoi_level` in 3: level targeted by `specific_eoi`.
- `int_out` out 1: interrupt request to the CPU.
- `isr` out 8: in-service register.
- `clear_irr` out 8: one-hot, one-cycle pulse telling the IRR to drop the acknowledged request.
- `vector` out 8: interrupt vector, `{vector_base, level}`.
- `vector_valid` out 1: one-cycle strobe when `vector` is updated.

## Operation
**Priority**
- 3-bit `lowest_prio` register; reset value 7, which makes level 0 the highest.
- Priority order starts at `(lowest_prio+1) mod 8` and ascends with wrap-around.
- Highest request = first set bit of `irr` in that order.
- Highest in-service = first set bit of `isr` in that order.
- Eligible = a request exists and either `isr` is all zero or the request ranks strictly above the highest in-service level (fully nested). An equal or lower level waits.

**FSM states**
- IDLE: on `inta`:
  - Latch `ack_level` = highest eligible request.
  - Set `isr[ack_level]`; pulse `clear_irr[ack_level]`.
  - Go to ACK1.
  - If no request is eligible (spurious), latch `ack_level`=7, leave `isr` unchanged, leave `clear_irr`=0.
- ACK1: on `inta`:
  - Drive `vector={vector_base, ack_level}` and pulse `vector_valid`.
  - If `auto_eoi` and the acknowledge was not spurious: clear `isr[ack_level]`; if `automatic_rotate`, set `lowest_prio`=`ack_level`.
  - Return to IDLE.
- `irr` changes during ACK1 do not alter `ack_level`.

**EOI**
- Accepted in any state.
- `eoi`: clear the highest in-service bit; if `automatic_rotate`, set `lowest_prio` to that level. If `isr`=0, no effect.
- `specific_eoi`: clear `isr[eoi_level]`; if `automatic_rotate`, set `lowest_prio`=`eoi_level`. If that bit is already 0, `isr` is unchanged but the rotation still applies.
- `eoi` and `specific_eoi` asserted together: the specific EOI wins.
- Same cycle as a first-INTA set of the same bit: the set wins. The EOI target is computed from the pre-update `isr`.

## Timing
- Reset values:
  - `int_out`=0, `isr`=0, `clear_irr`=0, `vector`=0, `vector_valid`=0.
  - `lowest_prio`=7, `ack_level`=0, state IDLE.
- `int_out` is registered. It rises 1 cycle after an eligible request appears in IDLE. It drops 1 cycle after the first `inta` and stays 0 through ACK1. It re-evaluates in IDLE.
- First `inta` at edge N → `isr` bit and `clear_irr` pulse visible after edge N. `clear_irr` lasts exactly 1 cycle.
- Second `inta` at edge M → `vector`/`vector_valid` visible after edge M. `vector` holds until the next acknowledge. Auto-EOI clear lands on the same edge.
- EOI effects are visible 1 cycle after the command.
- Reset asserted in ACK1 aborts the sequence: no vector is issued and the state is IDLE on release.

## Test plan
- `irr`=0x24, `vector_base`=0x08, reset priority → `int_out`=1. INTA#1 → `isr`=0x04, `clear_irr`=0x04. INTA#2 → `vector`=0x42, `vector_valid` pulse.
- `isr`=0x04 in service, `irr`=0x08 → `int_out` stays 0. Raise `irr`=0x01 → `int_out`=1; acknowledge → `isr`=0x05, `vector`=base|0.
- `automatic_rotate`=1, service level 3 then `eoi` → `lowest_prio`=3. Then `irr`=0x11 → level 4 is acknowledged first.
- `auto_eoi`=1, `irr`=0x80 → after INTA#2, `vector`=base|7 and `isr`=0x00.
- INTA#1 with `irr`=0 → `isr` unchanged, `clear_irr`=0. INTA#2 → `vector`=base|7 (spurious).
- `reset` pulsed mid-ACK1 → all outputs 0 immediately; a subsequent INTA starts a fresh sequence from IDLE.

Source files
------------

// File: rtl/pic_priority_isr.sv
// Priority resolver and in-service register for an 8259-style interrupt
// controller. Arbitrates masked requests under fully-nested or rotating
// priority, runs the two-pulse INTA acknowledge sequence and retires
// in-service levels on EOI or automatic EOI.
module pic_priority_isr #(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irr,
  input  logic               automatic_rotate,
  input  logic               auto_eoi,
  input  logic [4:0]         vector_base,
  input  logic               inta,
  input  logic               eoi,
  input  logic               specific_eoi,
  input  logic [2:0]         eoi_level,
  output logic               int_out,
  output logic [NUM_IRQ-1:0] isr,
  output logic [NUM_IRQ-1:0] clear_irr,
  output logic [7:0]         vector,
  output logic               vector_valid
);

  typedef enum logic [0:0] {IDLE, ACK1} state_t;

  state_t             state, state_next;
  logic [2:0]         lowest_prio, lowest_prio_next;
  logic [2:0]         ack_level, ack_level_next;
  logic               spurious, spurious_next;
  logic [NUM_IRQ-1:0] isr_next, clear_irr_next;
  logic [7:0]         vector_next;
  logic               vector_valid_next, int_out_next;

  logic [3:0]         req_pick, isr_pick;
  logic [2:0]         req_level, isr_level;
  logic               eligible;

  // Rank of the first set bit of vec when scanning upward from lp+1 with
  // wrap-around. Bit 3 flags that any bit was found, bits [2:0] give the
  // rank (0 = highest priority), so ranks compare directly.
  function automatic logic [3:0] first_set(input logic [7:0] vec,
                                           input logic [2:0] lp);
    logic [15:0] dbl;
    logic [3:0]  shift;
    logic [3:0]  r;
    shift = {1'b0, lp} + 4'd1;
    dbl   = {vec, vec} >> shift;
    r     = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (dbl[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // Priority resolution on the current request and in-service vectors.
  always_comb begin
    req_pick  = first_set(irr, lowest_prio);
    isr_pick  = first_set(isr, lowest_prio);
    req_level = lowest_prio + 3'd1 + req_pick[2:0];
    isr_level = lowest_prio + 3'd1 + isr_pick[2:0];
    eligible  = req_pick[3] && (!isr_pick[3] || (req_pick[2:0] < isr_pick[2:0]));
  end

  // Next-state and output logic for the acknowledge FSM and EOI handling.
  always_comb begin
    state_next        = state;
    isr_next          = isr;
    lowest_prio_next  = lowest_prio;
    ack_level_next    = ack_level;
    spurious_next     = spurious;
    clear_irr_next    = '0;
    vector_next       = vector;
    vector_valid_next = 1'b0;
    int_out_next      = 1'b0;

    // EOI targets come from the pre-update isr; a same-cycle INTA set
    // below overrides the clear.
    if (specific_eoi) begin
      isr_next[eoi_level] = 1'b0;
      if (automatic_rotate) lowest_prio_next = eoi_level;
    end else if (eoi && isr_pick[3]) begin
      isr_next[isr_level] = 1'b0;
      if (automatic_rotate) lowest_prio_next = isr_level;
    end

    case (state)
      IDLE: begin
        if (inta) begin
          state_next = ACK1;
          if (eligible) begin
            ack_level_next           = req_level;
            spurious_next            = 1'b0;
            isr_next[req_level]      = 1'b1;
            clear_irr_next[req_level] = 1'b1;
          end else begin
            ack_level_next = 3'd7;
            spurious_next  = 1'b1;
          end
        end else begin
          int_out_next = eligible;
        end
      end
      ACK1: begin
        if (inta) begin
          state_next        = IDLE;
          vector_next       = {vector_base, ack_level};
          vector_valid_next = 1'b1;
          if (auto_eoi && !spurious) begin
            isr_next[ack_level] = 1'b0;
            if (automatic_rotate) lowest_prio_next = ack_level;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers; reset aborts any acknowledge in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      isr          <= '0;
      lowest_prio  <= 3'd7;
      ack_level    <= 3'd0;
      spurious     <= 1'b0;
      clear_irr    <= '0;
      vector       <= 8'd0;
      vector_valid <= 1'b0;
      int_out      <= 1'b0;
    end else begin
      state        <= state_next;
      isr          <= isr_next;
      lowest_prio  <= lowest_prio_next;
      ack_level    <= ack_level_next;
      spurious     <= spurious_next;
      clear_irr    <= clear_irr_next;
      vector       <= vector_next;
      vector_valid <= vector_valid_next;
      int_out      <= int_out_next;
    end
  end

endmodule

// File: tb/tb_pic_priority_isr.sv
// Directed testbench for pic_priority_isr with hand-computed expectations.
module tb_pic_priority_isr;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irr;
  logic       automatic_rotate;
  logic       auto_eoi;
  logic [4:0] vector_base;
  logic       inta;
  logic       eoi;
  logic       specific_eoi;
  logic [2:0] eoi_level;
  logic       int_out;
  logic [7:0] isr;
  logic [7:0] clear_irr;
  logic [7:0] vector;
  logic       vector_valid;

  int checks   = 0;
  int failures = 0;

  pic_priority_isr #(.NUM_IRQ(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .irr              (irr),
    .automatic_rotate (automatic_rotate),
    .auto_eoi         (auto_eoi),
    .vector_base      (vector_base),
    .inta             (inta),
    .eoi              (eoi),
    .specific_eoi     (specific_eoi),
    .eoi_level        (eoi_level),
    .int_out          (int_out),
    .isr              (isr),
    .clear_irr        (clear_irr),
    .vector           (vector),
    .vector_valid     (vector_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_inta();
    inta = 1'b1;
    tick();
    inta = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  task automatic pulse_seoi(input logic [2:0] lvl);
    specific_eoi = 1'b1;
    eoi_level    = lvl;
    tick();
    specific_eoi = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irr = 8'h00; automatic_rotate = 1'b0; auto_eoi = 1'b0;
    vector_base = 5'h08; inta = 1'b0; eoi = 1'b0; specific_eoi = 1'b0;
    eoi_level = 3'd0;
    tick(); tick();
    chk("rst_int_out", {7'd0, int_out}, 8'h00);
    chk("rst_isr", isr, 8'h00);
    chk("rst_clear_irr", clear_irr, 8'h00);
    chk("rst_vector", vector, 8'h00);
    chk("rst_vector_valid", {7'd0, vector_valid}, 8'h00);
    reset = 1'b0;

    // Basic acknowledge, level 2 wins over level 5
    irr = 8'h24;
    tick();
    chk("t1_int_out", {7'd0, int_out}, 8'h01);
    pulse_inta();
    chk("t1_isr", isr, 8'h04);
    chk("t1_clear_irr", clear_irr, 8'h04);
    chk("t1_int_drop", {7'd0, int_out}, 8'h00);
    irr = 8'h20;
    tick();
    chk("t1_clear_once", clear_irr, 8'h00);
    chk("t1_int_ack1", {7'd0, int_out}, 8'h00);
    pulse_inta();
    chk("t1_vector", vector, 8'h42);
    chk("t1_vvalid", {7'd0, vector_valid}, 8'h01);
    tick();
    chk("t1_vvalid_pulse", {7'd0, vector_valid}, 8'h00);
    chk("t1_vector_hold", vector, 8'h42);

    // Fully nested: lower level blocked, higher level nests
    irr = 8'h08;
    tick(); tick();
    chk("t2_blocked", {7'd0, int_out}, 8'h00);
    irr = 8'h09;
    tick();
    chk("t2_nest_int", {7'd0, int_out}, 8'h01);
    pulse_inta();
    chk("t2_isr", isr, 8'h05);
    chk("t2_clear_irr", clear_irr, 8'h01);
    irr = 8'h00;
    pulse_inta();
    chk("t2_vector", vector, 8'h40);
    // Specific EOI beats non-specific in the same cycle
    eoi = 1'b1;
    pulse_seoi(3'd2);
    eoi = 1'b0;
    chk("t2_seoi_wins", isr, 8'h01);
    pulse_eoi();
    chk("t2_eoi_clear", isr, 8'h00);
    pulse_eoi();
    chk("t2_eoi_empty", isr, 8'h00);

    // Automatic rotation: level 3 retired becomes lowest, level 4 wins next
    automatic_rotate = 1'b1;
    irr = 8'h08;
    tick();
    pulse_inta();
    chk("t3_isr3", isr, 8'h08);
    irr = 8'h00;
    pulse_inta();
    chk("t3_vector3", vector, 8'h43);
    pulse_eoi();
    chk("t3_eoi", isr, 8'h00);
    irr = 8'h11;
    tick();
    chk("t3_int", {7'd0, int_out}, 8'h01);
    pulse_inta();
    chk("t3_isr_rot", isr, 8'h10);
    chk("t3_clear_rot", clear_irr, 8'h10);
    irr = 8'h00;
    pulse_inta();
    chk("t3_vector_rot", vector, 8'h44);
    pulse_eoi();
    chk("t3_eoi4", isr, 8'h00);
    // Specific EOI on an idle level still rotates: lowest becomes 7
    pulse_seoi(3'd7);
    chk("t3_seoi_noop", isr, 8'h00);
    irr = 8'h81;
    tick();
    pulse_inta();
    chk("t3_isr_restored", isr, 8'h01);
    irr = 8'h80;
    pulse_inta();
    chk("t3_vector_restored", vector, 8'h40);
    automatic_rotate = 1'b0;
    irr = 8'h00;
    pulse_seoi(3'd0);
    chk("t3_seoi_clear", isr, 8'h00);

    // Automatic EOI
    auto_eoi = 1'b1;
    irr = 8'h80;
    tick();
    chk("t4_int", {7'd0, int_out}, 8'h01);
    pulse_inta();
    chk("t4_isr_set", isr, 8'h80);
    chk("t4_clear_irr", clear_irr, 8'h80);
    irr = 8'h00;
    pulse_inta();
    chk("t4_vector", vector, 8'h47);
    chk("t4_vvalid", {7'd0, vector_valid}, 8'h01);
    chk("t4_isr_auto", isr, 8'h00);
    auto_eoi = 1'b0;

    // Spurious acknowledge
    vector_base = 5'h1F;
    tick();
    chk("t5_no_int", {7'd0, int_out}, 8'h00);
    pulse_inta();
    chk("t5_isr", isr, 8'h00);
    chk("t5_clear_irr", clear_irr, 8'h00);
    pulse_inta();
    chk("t5_vector", vector, 8'hFF);
    chk("t5_vvalid", {7'd0, vector_valid}, 8'h01);
    vector_base = 5'h08;

    // Reset asserted in ACK1 aborts the sequence
    irr = 8'h02;
    tick();
    pulse_inta();
    chk("t6_isr_pre", isr, 8'h02);
    reset = 1'b1;
    #1;
    chk("t6_async_isr", isr, 8'h00);
    chk("t6_async_int", {7'd0, int_out}, 8'h00);
    chk("t6_async_vector", vector, 8'h00);
    chk("t6_async_clear", clear_irr, 8'h00);
    tick();
    reset = 1'b0;
    tick();
    chk("t6_int_again", {7'd0, int_out}, 8'h01);
    pulse_inta();
    chk("t6_fresh_isr", isr, 8'h02);
    chk("t6_fresh_clear", clear_irr, 8'h02);
    chk("t6_no_vvalid", {7'd0, vector_valid}, 8'h00);
    irr = 8'h00;
    pulse_inta();
    chk("t6_vector", vector, 8'h41);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
